// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the MIPS boot loader: FSM states and frame layout.
package mips_boot_pkg;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERR
  } boot_state_e;

  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
  localparam logic [7:0]  CSUM_INIT      = 8'h00;

endpackage

// File: rtl/boot_word_assembler.sv
// Big-endian byte-to-word assembler: the first byte of a word lands in bits [31:24].
module boot_word_assembler
  import mips_boot_pkg::*;
(
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_in,
  output logic [31:0]           word,
  output logic                  word_valid,
  output logic [BYTE_CNT_W-1:0] byte_cnt
);

  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

  logic [23:0]           shift_q, shift_d;
  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;

  // The completed word is presented combinationally with the 4th byte so the
  // caller can register it alongside its own write address.
  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    word       = {shift_q, byte_in};
    word_valid = byte_valid && (cnt_q == LAST_BYTE);
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_valid) begin
      shift_d = {shift_q[15:0], byte_in};
      cnt_d   = cnt_q + BYTE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    cnt_q   <= cnt_d;
  end

  assign byte_cnt = cnt_q;

endmodule

// File: rtl/mips_boot_loader.sv
// Holds the MIPS core in reset while a length/payload/XOR-checksum frame is
// written into instruction memory, then releases the core on a good checksum.
module mips_boot_loader
  import mips_boot_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              boot_done,
  output logic              boot_error
);

  localparam logic [16:0] MAX_WORDS = 17'(IMEM_WORDS);

  boot_state_e       state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        csum_q, csum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rx_ready_q, rx_ready_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic                  accept;
  logic                  asm_clear;
  logic                  asm_valid;
  logic [31:0]           asm_word;
  logic                  asm_word_valid;
  logic [BYTE_CNT_W-1:0] asm_byte_cnt;
  logic [15:0]           len_full;

  assign accept    = rx_valid && rx_ready_q;
  assign asm_valid = accept && (state_q == S_DATA);
  assign asm_clear = reset || (state_q != S_DATA);
  assign len_full  = {count_q[15:8], rx_byte};

  boot_word_assembler u_asm (
    .clk        (clk),
    .clear      (asm_clear),
    .byte_valid (asm_valid),
    .byte_in    (rx_byte),
    .word       (asm_word),
    .word_valid (asm_word_valid),
    .byte_cnt   (asm_byte_cnt)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_LEN_HI: begin
        if (accept) begin
          count_d = {rx_byte, 8'h00};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          count_d = len_full;
          if ({1'b0, len_full} > MAX_WORDS) state_d = S_ERR;
          else if (len_full == 16'h0000)    state_d = S_CSUM;
          else                              state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d = csum_q ^ rx_byte;
          if (asm_word_valid) begin
            we_d    = 1'b1;
            addr_d  = idx_q;
            wdata_d = asm_word;
            idx_d   = idx_q + ADDR_W'(1);
            // Compare in 17 bits so a full-depth image ends without relying on index wrap.
            if (17'(idx_q) + 17'd1 == {1'b0, count_q}) state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (accept) state_d = (rx_byte == csum_q) ? S_RUN : S_ERR;
      end
      default: state_d = state_q;
    endcase

    rx_ready_d  = (state_d != S_RUN) && (state_d != S_ERR);
    cpu_reset_d = (state_d != S_RUN);
    done_d      = (state_d == S_RUN);
    err_d       = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LEN_HI;
      count_q     <= '0;
      idx_q       <= '0;
      csum_q      <= CSUM_INIT;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rx_ready_q  <= 1'b1;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rx_ready_q  <= rx_ready_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // A word may only be partially assembled while payload is being received.
  a_partial_only_in_data : assert property (@(posedge clk) disable iff (reset)
    (state_q != S_DATA) |-> (asm_byte_cnt == '0));

  assign rx_ready   = rx_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign boot_done  = done_q;
  assign boot_error = err_q;

endmodule

// File: doc/mips_boot_loader.md
# mips_boot_loader

Upstream neighbour of the single-cycle MIPS core. It holds the core in reset and receives a byte-serial program image over a valid/ready byte stream. It writes the image word by word into instruction memory, verifies an XOR checksum, then releases the core's reset. It replaces the simulation-only "pulse reset, preloaded memory" bring-up with a real load path usable on the bench and on hardware.

## Interface
Parameters:
- IMEM_WORDS, 256: instruction memory depth in 32-bit words.
- ADDR_W, 8: word-address width; must satisfy 2**ADDR_W >= IMEM_WORDS.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; restarts the load sequence.
- rx_valid  in  1  upstream byte present.
- rx_byte  in  8  upstream byte.
- rx_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word index being written.
- imem_wdata  out  32  word being written.
- cpu_reset  out  1  drives the MIPS core reset; high while the core must not run.
- boot_done  out  1  image loaded and verified; core running.
- boot_error  out  1  frame rejected; core held in reset.

## Operation
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N×4 payload bytes, then CSUM.
  - Payload words are big-endian: the first byte is bits [31:24].
  - CSUM = XOR of all payload bytes; length bytes are excluded.
- A byte is accepted when rx_valid && rx_ready; nothing else advances the FSM.
- FSM states: S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_RUN, S_ERR.
  - S_LEN_HI: accept byte, store as count[15:8], go to S_LEN_LO.
  - S_LEN_LO: accept byte, form the full count N.
    - If N > IMEM_WORDS, go to S_ERR.
    - If N == 0, go to S_CSUM.
    - Otherwise go to S_DATA.
  - S_DATA:
    - Shift each byte into the word assembler.
    - XOR each byte into the running checksum.
    - On the 4th byte of a word: pulse imem_we, increment the word index, clear the byte counter.
    - After word N-1 is written, go to S_CSUM.
  - S_CSUM: accept byte.
    - Equal to the running checksum: go to S_RUN.
    - Otherwise: go to S_ERR.
  - S_RUN: terminal until reset.
  - S_ERR: terminal until reset.
- Output per state:
  - rx_ready = 1 in S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM; 0 in S_RUN and S_ERR.
  - cpu_reset = 1 in every state except S_RUN.
  - boot_done = (state == S_RUN).
  - boot_error = (state == S_ERR).
- Reset values: state S_LEN_HI, word index 0, byte counter 0, checksum 0x00, imem_we 0, imem_addr 0, imem_wdata 0, cpu_reset 1, boot_done 0, boot_error 0.
- Arithmetic and width rules:
  - Word index is ADDR_W bits, but completion is compared against the 16-bit N zero-extended.
  - N == IMEM_WORDS is legal and fills memory exactly; no wrap-around is possible.
  - The checksum is 8-bit and has no carry.
- Boundary cases:
  - rx_valid gaps inside a word stall the assembler; partial bytes are retained.
  - Bytes arriving in S_RUN or S_ERR are not accepted, because rx_ready = 0.
  - Reset mid-load: the FSM restarts at S_LEN_HI and cpu_reset stays 1. Words already written to instruction memory are not erased; the next load overwrites them.
  - Reset while in S_RUN re-asserts cpu_reset in the following cycle and restarts the load.

## Timing
- All outputs are registered.
- imem_we, imem_addr and imem_wdata are valid in the cycle after the 4th byte of a word is accepted. The strobe is high for exactly one cycle.
- Accepting the CSUM byte in cycle T: cpu_reset falls and boot_done rises in cycle T+1. The core fetches from PC reset address 0 starting at T+1.
- A mismatching CSUM, or an oversize N, gives boot_error = 1 one cycle after the offending byte.
- Throughput: one byte per cycle, so N words plus header take 4N+3 accepted bytes.

## Structure
- Shared package mips_boot_pkg:
  - the state enum;
  - LEN_BYTES = 2;
  - BYTES_PER_WORD = 4;
  - CSUM_INIT = 8'h00.
- One natural sub-module, boot_word_assembler. It takes a byte and a valid, and produces a 32-bit word, a word_valid pulse and the byte counter, with a clear input. It is instantiated once.
- The FSM, word index and checksum live in mips_boot_loader.

## Test plan
- Load 3 words 0x20080005, 0x20090003, 0x01095020, with CSUM = XOR of the 12 bytes.
  - imem_we pulses at addresses 0, 1, 2 with those exact words.
  - boot_done = 1 and cpu_reset = 0 one cycle after the CSUM byte.
- Same frame with CSUM XOR 0x01.
  - boot_error = 1, cpu_reset stays 1, rx_ready = 0.
  - Later bytes are ignored.
- N = 0x0101 (257 > 256).
  - boot_error rises after LEN_LO; no imem_we is ever issued.
- N = 0, CSUM = 0x00.
  - boot_done rises after 3 bytes; no writes occur.
- Random rx_valid gaps (0–3 idle cycles) on the 3-word frame.
  - Memory contents and the checksum outcome are identical to the gap-free run.
- Reset asserted after 6 payload bytes, then a full 2-word frame is sent.
  - Writes start at address 0 again and boot_done follows.
  - cpu_reset is never deasserted before that.
